// File: rtl/bus_ctrl.sv
// CPU bus cycle controller: ROM/RAM chip selects with wait states, bus sizing and DMA hold handshake.
// Optional ROM timeout with BUSERR pulse is built when BUS_CTRL_TIMEOUT_EN is defined.
module bus_ctrl #(
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        BCYSTn,
    input  logic        MRQn,
    input  logic [31:0] A,
    output logic        READYn,
    output logic        SZRQn,
    output logic        ROM_CEn,
    input  logic        ROM_READYn,
    output logic        RAM_CEn,
    output logic        HLDRQn,
    input  logic        HLDAKn,
    input  logic        DMA_REQ,
    output logic        DMA_GNT,
    output logic        BUSERR
);

    localparam int unsigned MaxWait = (ROM_WAIT > RAM_WAIT) ? ROM_WAIT : RAM_WAIT;
    localparam int unsigned CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StReady, StHoldReq, StHold} state_e;
    typedef enum logic [1:0] {RegNone, RegRom, RegRam} region_e;

    state_e          state;
    region_e         region;
    region_e         dec_region;
    logic [CntW-1:0] wait_cnt;
    logic [CntW-1:0] load_val;
    logic            bus_start;

    // Low address bits never take part in region decode.
    logic unused_a;
    assign unused_a = ^A[19:0];

    assign bus_start = !BCYSTn && !MRQn;

    always_comb begin
        if (A[31:20] == 12'hFFF) begin
            dec_region = RegRom;
        end else if (!A[31]) begin
            dec_region = RegRam;
        end else begin
            dec_region = RegNone;
        end
    end

    always_comb begin
        case (dec_region)
            RegRom:  load_val = CntW'(ROM_WAIT);
            RegRam:  load_val = CntW'(RAM_WAIT);
            default: load_val = '0;
        endcase
    end

`ifdef BUS_CTRL_TIMEOUT_EN
    localparam int unsigned TimW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TimW-1:0] tout_cnt;
    logic            buserr_q;
    logic            tout_hit;

    assign tout_hit = (region == RegRom) && (tout_cnt == TimW'(TIMEOUT - 1));
    assign BUSERR   = buserr_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TIMEOUT);
    assign BUSERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= StIdle;
            region   <= RegNone;
            wait_cnt <= '0;
            READYn   <= 1'b1;
            SZRQn    <= 1'b1;
            ROM_CEn  <= 1'b1;
            RAM_CEn  <= 1'b1;
            HLDRQn   <= 1'b1;
            DMA_GNT  <= 1'b0;
`ifdef BUS_CTRL_TIMEOUT_EN
            tout_cnt <= '0;
            buserr_q <= 1'b0;
`endif
        end else if (CE) begin
            case (state)
                StIdle: begin
                    // A CPU cycle start takes priority over a pending DMA request.
                    if (bus_start) begin
                        region   <= dec_region;
                        wait_cnt <= load_val;
                        ROM_CEn  <= (dec_region != RegRom);
                        RAM_CEn  <= (dec_region != RegRam);
                        SZRQn    <= (dec_region != RegRom);
`ifdef BUS_CTRL_TIMEOUT_EN
                        tout_cnt <= '0;
`endif
                        if (load_val != '0) begin
                            state <= StWait;
                        end else begin
                            state  <= StReady;
                            READYn <= 1'b0;
                        end
                    end else if (DMA_REQ) begin
                        state  <= StHoldReq;
                        HLDRQn <= 1'b0;
                    end
                end
                StWait: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`ifdef BUS_CTRL_TIMEOUT_EN
                    tout_cnt <= tout_cnt + 1'b1;
`endif
                    if (wait_cnt == '0 && (region != RegRom || !ROM_READYn)) begin
                        state  <= StReady;
                        READYn <= 1'b0;
                    end
`ifdef BUS_CTRL_TIMEOUT_EN
                    else if (tout_hit) begin
                        state    <= StReady;
                        READYn   <= 1'b0;
                        buserr_q <= 1'b1;
                    end
`endif
                end
                StReady: begin
                    state   <= StIdle;
                    region  <= RegNone;
                    READYn  <= 1'b1;
                    SZRQn   <= 1'b1;
                    ROM_CEn <= 1'b1;
                    RAM_CEn <= 1'b1;
`ifdef BUS_CTRL_TIMEOUT_EN
                    buserr_q <= 1'b0;
`endif
                end
                StHoldReq: begin
                    if (!DMA_REQ) begin
                        state  <= StIdle;
                        HLDRQn <= 1'b1;
                    end else if (!HLDAKn) begin
                        state   <= StHold;
                        DMA_GNT <= 1'b1;
                    end
                end
                StHold: begin
                    if (!DMA_REQ) begin
                        state   <= StIdle;
                        HLDRQn  <= 1'b1;
                        DMA_GNT <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
